// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and a multi-cycle memory (slave).
// Latency: none, wires only.
// Backpressure: the master holds mem_req/addr/wdata/we until mem_gnt; read data returns on mem_rvalid.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store initiator: one datapath op at a time onto a req/gnt + rvalid memory bus.
// Latency: store 3, load 4, no-mem/error 2 cycles from cpu_valid to done (no wait states).
// Backpressure: busy stalls the datapath; waits on mem_gnt / mem_rvalid, aborts with err at TIMEOUT.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] memtoreg_out,
  load_store_unit_if.master mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter only needs to reach TIMEOUT-1; the abort decision is taken on the
  // cycle whose increment would land there, so REQ+RESP lasts at most TIMEOUT-1 cycles.
  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              m2r_q;
  logic              err_q, err_nxt;
  logic [DATA_W-1:0] wb_q, wb_nxt;
  logic              wb_upd;
  logic              timeout_hit;
  logic              bad_op;

  assign timeout_hit = (cnt == CNT_LAST);
  // Both strobes, or a memory access that is not word aligned, never reaches the bus.
  assign bad_op = (MemRead & MemWrite) | ((MemRead | MemWrite) & (alu_result[1:0] != 2'b00));

  // Next state, completion status and writeback value for the DONE entry.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    wb_upd    = 1'b0;
    wb_nxt    = wb_q;
    case (state)
      S_IDLE: begin
        if (cpu_valid) begin
          if (bad_op) begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
          end else if (!MemRead && !MemWrite) begin
            state_nxt = S_DONE;
            wb_upd    = 1'b1;
            wb_nxt    = DATA_W'(alu_result);
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A grant on the limit cycle still completes normally.
        if (mem.mem_gnt) begin
          if (we_q) begin
            state_nxt = S_DONE;
            wb_upd    = 1'b1;
            wb_nxt    = DATA_W'(addr_q);
          end else begin
            state_nxt = S_RESP;
          end
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_RESP: begin
        if (mem.mem_rvalid) begin
          state_nxt = S_DONE;
          wb_upd    = 1'b1;
          wb_nxt    = m2r_q ? mem.mem_rdata : DATA_W'(addr_q);
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, cycle budget counter and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      wb_q  <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (wb_upd) begin
        wb_q <= wb_nxt;
      end
      if ((state == S_REQ) || (state == S_RESP)) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Operation latches: captured once at acceptance, held for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else if ((state == S_IDLE) && cpu_valid) begin
      addr_q  <= alu_result;
      wdata_q <= write_data;
      we_q    <= MemWrite;
      m2r_q   <= MemtoReg;
    end
  end

  // Decoded from state so reset removes mem_req and busy without waiting for a clock.
  assign mem.mem_req   = (state == S_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign err          = done & err_q;
  assign memtoreg_out = wb_q;

endmodule
